// File: rtl/aes_pkg.sv
// Shared AES constants, byte/column/state containers and the column-buffer FSM encoding.
// The state container is indexed st[row][col] so ShiftRows reads as a row rotation.
package aes_pkg;

  localparam int AES_NB     = 4;
  localparam int AES_BYTE_W = 8;

  typedef logic [AES_BYTE_W-1:0] aes_byte_t;

  // One row of the state, indexed by column.
  typedef aes_byte_t [AES_NB-1:0] aes_row_t;
  // One column of the state, indexed by row.
  typedef aes_byte_t [AES_NB-1:0] aes_col_t;
  // Full 128-bit state, indexed [row][col].
  typedef aes_row_t  [AES_NB-1:0] aes_state_t;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } aes_colbuf_state_t;

  localparam logic [1:0] CNT_LAST = 2'd3;

endpackage

// File: rtl/aes_shiftrows_colsel.sv
// Combinational ShiftRows column select: row r of output column cnt comes from
// column (cnt + r) mod 4 of the held state.
module aes_shiftrows_colsel
  import aes_pkg::*;
(
  input  aes_state_t st,
  input  logic [1:0] cnt,
  output aes_col_t   col
);

  always_comb begin
    for (int r = 0; r < AES_NB; r++) begin
      // 2-bit sum wraps naturally, giving the mod-4 rotation.
      col[r] = st[r][2'(cnt + 2'(r))];
    end
  end

endmodule

// File: rtl/aes_shiftrows_colbuf.sv
// Per-share column-serial state buffer: loads four columns, then drains the
// ShiftRows-permuted state one column per cycle toward MixColumn.
module aes_shiftrows_colbuf
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:1] in_row1,
  input  logic [8:1] in_row2,
  input  logic [8:1] in_row3,
  input  logic [8:1] in_row4,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:1] out_row1,
  output logic [8:1] out_row2,
  output logic [8:1] out_row3,
  output logic [8:1] out_row4,
  output logic [1:0] out_col,
  output logic       out_last
);

  aes_colbuf_state_t state, state_d;
  logic [1:0]        cnt, cnt_d;
  aes_state_t        st, st_d;
  aes_col_t          shifted;
  logic              in_fire;
  logic              out_fire;

  // Handshake qualifiers depend only on the state register.
  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_DRAIN);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // NOTE: every variable gets its default before any branch, so no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    st_d    = st;
    if (clear) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
      st_d    = '0;
    end else if (in_fire) begin
      st_d[0][cnt] = in_row1;
      st_d[1][cnt] = in_row2;
      st_d[2][cnt] = in_row3;
      st_d[3][cnt] = in_row4;
      cnt_d        = cnt + 2'd1;
      if (cnt == CNT_LAST) state_d = ST_DRAIN;
    end else if (out_fire) begin
      cnt_d = cnt + 2'd1;
      if (cnt == CNT_LAST) begin
        state_d = ST_LOAD;
        // Scrub the share once it has been handed to MixColumn.
        st_d    = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      cnt   <= '0;
      // NOTE: the 16-byte buffer is reset too; it is flops, not RAM, and must not leak a share after reset.
      st    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      st    <= st_d;
    end
  end

  aes_shiftrows_colsel u_colsel (
    .st  (st),
    .cnt (cnt),
    .col (shifted)
  );

  // Outputs are forced to zero outside DRAIN so no stale share data reaches MixColumn.
  assign out_row1 = out_valid ? shifted[0] : '0;
  assign out_row2 = out_valid ? shifted[1] : '0;
  assign out_row3 = out_valid ? shifted[2] : '0;
  assign out_row4 = out_valid ? shifted[3] : '0;
  assign out_col  = out_valid ? cnt : 2'd0;
  assign out_last = out_valid & (cnt == CNT_LAST);

endmodule

// File: tb/tb_aes_shiftrows_colbuf.sv
// Self-checking bench for aes_shiftrows_colbuf: directed and randomized states
// compared against a row-rotation ShiftRows model held in the bench.
module tb_aes_shiftrows_colbuf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [8:1] in_row1, in_row2, in_row3, in_row4;
  logic       out_valid;
  logic       out_ready;
  logic [8:1] out_row1, out_row2, out_row3, out_row4;
  logic [1:0] out_col;
  logic       out_last;

  int checks = 0;
  int errors = 0;

  // Reference state, indexed [row][col].
  logic [7:0] ref_st [4][4];

  always #5 clk = ~clk;

  aes_shiftrows_colbuf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row1   (in_row1),
    .in_row2   (in_row2),
    .in_row3   (in_row3),
    .in_row4   (in_row4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row1  (out_row1),
    .out_row2  (out_row2),
    .out_row3  (out_row3),
    .out_row4  (out_row4),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] out_bus();
    return {out_row1, out_row2, out_row3, out_row4};
  endfunction

  // ShiftRows: row r is rotated left by r, so output column k row r = st[r][(k+r)%4].
  function automatic logic [31:0] exp_col(input int k);
    logic [31:0] v;
    for (int r = 0; r < 4; r++) v[31-8*r -: 8] = ref_st[r][(k + r) % 4];
    return v;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) ref_st[r][c] = 8'($urandom);
  endtask

  task automatic garbage_rows();
    {in_row1, in_row2, in_row3, in_row4} = $urandom;
  endtask

  task automatic drive_col(input int c);
    in_valid = 1'b1;
    {in_row1, in_row2, in_row3, in_row4} = {ref_st[0][c], ref_st[1][c], ref_st[2][c], ref_st[3][c]};
  endtask

  task automatic load_state(input bit stalls);
    for (int c = 0; c < 4; c++) begin
      if (stalls) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid  = 1'b0;
          out_ready = 1'($urandom);
          garbage_rows();
          check("in_ready_stall", 32'(in_ready), 32'd1);
          tick();
        end
      end
      drive_col(c);
      check("in_ready_load", 32'(in_ready), 32'd1);
      check("out_valid_load", 32'(out_valid), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    garbage_rows();
  endtask

  task automatic drain_state(input bit stalls, input int hold_col);
    for (int k = 0; k < 4; k++) begin
      if (k == hold_col) begin
        out_ready = 1'b0;
        repeat (5) begin
          check("hold_bus", out_bus(), exp_col(k));
          check("hold_col", 32'(out_col), 32'(k));
          check("hold_last", 32'(out_last), 32'(k == 3));
          check("hold_valid", 32'(out_valid), 32'd1);
          tick();
        end
      end else if (stalls) begin
        repeat ($urandom_range(0, 2)) begin
          out_ready = 1'b0;
          check("stall_bus", out_bus(), exp_col(k));
          tick();
        end
      end
      out_ready = 1'b1;
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_in_ready", 32'(in_ready), 32'd0);
      check("drain_bus", out_bus(), exp_col(k));
      check("drain_col", 32'(out_col), 32'(k));
      check("drain_last", 32'(out_last), 32'(k == 3));
      tick();
      out_ready = 1'b0;
    end
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_bus", out_bus(), 32'd0);
    check("post_col", 32'(out_col), 32'd0);
    check("post_last", 32'(out_last), 32'd0);
  endtask

  initial begin
    logic [31:0] fips_cols [4];
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    {in_row1, in_row2, in_row3, in_row4} = '0;

    // Reset values.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bus", out_bus(), 32'd0);
    check("rst_col", 32'(out_col), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 round-1 S-box output, column-major.
    fips_cols[0] = 32'hd42711ae;
    fips_cols[1] = 32'he0bf98f1;
    fips_cols[2] = 32'hb8b45de5;
    fips_cols[3] = 32'h1e415230;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) ref_st[r][c] = fips_cols[c][31-8*r -: 8];
    load_state(1'b0);
    check("fips_col0", out_bus(), 32'hd4bf5d30);
    drain_state(1'b0, -1);

    // Index pattern with a 5-cycle backpressure hold at column 2.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) ref_st[r][c] = 8'(16 * r + c);
    load_state(1'b1);
    check("index_col0", out_bus(), 32'h00112233);
    drain_state(1'b0, 2);

    // Randomized states with random input gaps and output stalls.
    repeat (4) begin
      fill_random();
      load_state(1'b1);
      drain_state(1'b1, -1);
    end

    // Clear after two columns, with a beat presented in the same cycle.
    fill_random();
    for (int c = 0; c < 2; c++) begin
      drive_col(c);
      tick();
    end
    in_valid = 1'b1;
    garbage_rows();
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_load_in_ready", 32'(in_ready), 32'd1);
    check("clr_load_out_valid", 32'(out_valid), 32'd0);
    check("clr_load_bus", out_bus(), 32'd0);
    fill_random();
    load_state(1'b0);
    drain_state(1'b0, -1);

    // Clear mid-drain.
    fill_random();
    load_state(1'b0);
    out_ready = 1'b1;
    check("clrd_col0", out_bus(), exp_col(0));
    tick();
    out_ready = 1'b0;
    check("clrd_col1_idx", 32'(out_col), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrd_out_valid", 32'(out_valid), 32'd0);
    check("clrd_in_ready", 32'(in_ready), 32'd1);
    check("clrd_bus", out_bus(), 32'd0);
    fill_random();
    load_state(1'b0);
    drain_state(1'b0, -1);

    // Asynchronous reset pulse between edges mid-drain.
    fill_random();
    load_state(1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_bus", out_bus(), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_col", 32'(out_col), 32'd0);
    check("arst_last", 32'(out_last), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    fill_random();
    load_state(1'b0);
    drain_state(1'b0, -1);

    // Back-to-back: in_valid and out_ready held high across two states.
    for (int s = 0; s < 2; s++) begin
      fill_random();
      for (int t = 0; t < 8; t++) begin
        out_ready = 1'b1;
        if (t < 4) begin
          drive_col(t);
          check("b2b_in_ready_load", 32'(in_ready), 32'd1);
          check("b2b_valid_load", 32'(out_valid), 32'd0);
        end else begin
          in_valid = 1'b1;
          garbage_rows();
          check("b2b_in_ready_drain", 32'(in_ready), 32'd0);
          check("b2b_valid_drain", 32'(out_valid), 32'd1);
          check("b2b_bus", out_bus(), exp_col(t - 4));
          check("b2b_last", 32'(out_last), 32'(t == 7));
        end
        tick();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_end_in_ready", 32'(in_ready), 32'd1);
    check("b2b_end_valid", 32'(out_valid), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
